// File: rtl/adc_wave_conditioner_if.sv
// Sample-path bundle for adc_wave_conditioner: ADC samples in, conditioned
// WAVE/strobe/status out. The slave modport is the conditioner side.
interface adc_wave_conditioner_if #(
    parameter int unsigned ADC_W = 12
);
    logic [ADC_W-1:0] ADC_DATA;
    logic             ADC_VALID;
    logic [2:0]       GAIN;
    logic [15:0]      WAVE;
    logic             SAMPLE_TR;
    logic             CLIP;
    logic             OVERRUN;

    modport master (
        output ADC_DATA, ADC_VALID, GAIN,
        input  WAVE, SAMPLE_TR, CLIP, OVERRUN
    );

    modport slave (
        input  ADC_DATA, ADC_VALID, GAIN,
        output WAVE, SAMPLE_TR, CLIP, OVERRUN
    );
endinterface

// File: rtl/adc_wave_conditioner.sv
// DC-removing IIR tracker, power-of-two gain with saturation, and a stretched
// SAMPLE_TR strobe around which WAVE is held stable for the downstream buffer.
module adc_wave_conditioner #(
    parameter int unsigned ADC_W    = 12,
    parameter int unsigned DC_SHIFT = 6,
    parameter int unsigned TR_HIGH  = 4
) (
    input logic AUDIO_MCLK,
    input logic RESET,
    adc_wave_conditioner_if.slave bus
);
    localparam int unsigned AW    = ADC_W + DC_SHIFT;
    localparam int unsigned CNT_W = (TR_HIGH > 1) ? $clog2(TR_HIGH) : 1;
    localparam logic [AW-1:0]    ACC_INIT = AW'(1) << (ADC_W - 1 + DC_SHIFT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TR_HIGH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic signed [ADC_W:0] cen_q, cen_d;
    logic                stb_q, stb_d;
    logic [15:0]         pend_q, pend_d;
    logic                pend_sat_q, pend_sat_d;
    logic                pend_v_q, pend_v_d;
    logic [15:0]         wave_q, wave_d;
    logic                clip_q, clip_d;
    logic                tr_q, tr_d;
    logic                overrun_q, overrun_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [ADC_W-1:0]    dc_est;
    logic [AW:0]         acc_sum;
    logic signed [31:0]  cen_ext;
    logic signed [31:0]  sh;
    logic [4:0]          shamt;
    logic [15:0]         sat_val;
    logic                sat_flag;
    logic                consume;

    always_comb begin
        dc_est  = acc_q[AW-1:DC_SHIFT];
        acc_sum = {1'b0, acc_q} + (AW+1)'(bus.ADC_DATA) - (AW+1)'(dc_est);
        cen_ext = {{(31-ADC_W){cen_q[ADC_W]}}, cen_q};
        shamt   = 5'(16 - ADC_W) + 5'(bus.GAIN);
        sh      = cen_ext <<< shamt;
        sat_flag = 1'b0;
        sat_val  = sh[15:0];
        if (sh > 32'sd32767) begin
            sat_val  = 16'h7FFF;
            sat_flag = 1'b1;
        end else if (sh < -32'sd32768) begin
            sat_val  = 16'h8000;
            sat_flag = 1'b1;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        cen_d      = cen_q;
        stb_d      = bus.ADC_VALID;
        pend_d     = pend_q;
        pend_sat_d = pend_sat_q;
        pend_v_d   = pend_v_q;
        wave_d     = wave_q;
        clip_d     = clip_q;
        tr_d       = tr_q;
        overrun_d  = overrun_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        consume    = 1'b0;

        if (bus.ADC_VALID) begin
            acc_d = acc_sum[AW-1:0];
            cen_d = $signed({1'b0, bus.ADC_DATA}) - $signed({1'b0, dc_est});
        end

        unique case (state_q)
            IDLE: if (pend_v_q) begin
                consume  = 1'b1;
                wave_d   = pend_q;
                clip_d   = pend_sat_q;
                pend_v_d = 1'b0;
                state_d  = SETUP;
            end
            SETUP: begin
                tr_d    = 1'b1;
                cnt_d   = '0;
                state_d = HIGH;
            end
            HIGH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    tr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stage B write comes after the IDLE load so a same-edge arrival wins.
        if (stb_q) begin
            if (pend_v_q && !consume) overrun_d = 1'b1;
            pend_d     = sat_val;
            pend_sat_d = sat_flag;
            pend_v_d   = 1'b1;
        end
    end

    always_ff @(posedge AUDIO_MCLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            acc_q      <= ACC_INIT;
            cen_q      <= '0;
            stb_q      <= 1'b0;
            pend_q     <= '0;
            pend_sat_q <= 1'b0;
            pend_v_q   <= 1'b0;
            wave_q     <= '0;
            clip_q     <= 1'b0;
            tr_q       <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cen_q      <= cen_d;
            stb_q      <= stb_d;
            pend_q     <= pend_d;
            pend_sat_q <= pend_sat_d;
            pend_v_q   <= pend_v_d;
            wave_q     <= wave_d;
            clip_q     <= clip_d;
            tr_q       <= tr_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.WAVE      = wave_q;
    assign bus.SAMPLE_TR = tr_q;
    assign bus.CLIP      = clip_q;
    assign bus.OVERRUN   = overrun_q;
endmodule

// File: tb/tb_adc_wave_conditioner.sv
// Directed bench for adc_wave_conditioner at default parameters.
module tb_adc_wave_conditioner;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_wave_conditioner_if #(.ADC_W(12)) bus ();

    adc_wave_conditioner #(.ADC_W(12), .DC_SHIFT(6), .TR_HIGH(4)) dut (
        .AUDIO_MCLK(clk),
        .RESET     (rst),
        .bus       (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ADC_VALID = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Presents one sample at edge 0 and returns just after edge 2 (WAVE loaded).
    task automatic send(input logic [11:0] d, input logic [2:0] g);
        bus.ADC_DATA  = d;
        bus.GAIN      = g;
        bus.ADC_VALID = 1'b1;
        tick();
        bus.ADC_VALID = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic signed [15:0] prev, cur;
        logic [15:0] w_prev;
        logic        tr_prev;
        int          hi_run, lo_run;
        bit          seen_fall;

        rst = 1'b1;
        bus.ADC_DATA  = '0;
        bus.ADC_VALID = 1'b0;
        bus.GAIN      = '0;

        // 1: reset state, mid-scale sample, strobe timing
        do_reset();
        chk("rst_wave", 32'(bus.WAVE), 32'h0);
        chk("rst_tr", 32'(bus.SAMPLE_TR), 32'h0);
        chk("rst_clip", 32'(bus.CLIP), 32'h0);
        chk("rst_ovr", 32'(bus.OVERRUN), 32'h0);
        bus.ADC_DATA = 12'h800; bus.ADC_VALID = 1'b1;
        tick();
        bus.ADC_VALID = 1'b0;
        tick();
        chk("e1_tr", 32'(bus.SAMPLE_TR), 32'h0);
        tick();
        chk("e2_wave", 32'(bus.WAVE), 32'h0);
        chk("e2_clip", 32'(bus.CLIP), 32'h0);
        chk("e2_tr", 32'(bus.SAMPLE_TR), 32'h0);
        for (int i = 3; i <= 6; i++) begin
            tick();
            chk($sformatf("e%0d_tr_hi", i), 32'(bus.SAMPLE_TR), 32'h1);
        end
        tick();
        chk("e7_tr_lo", 32'(bus.SAMPLE_TR), 32'h0);
        repeat (6) tick();

        // 2: gain 0, positive and exact negative full scale
        do_reset();
        send(12'h900, 3'd0);
        chk("p900_g0_wave", 32'(bus.WAVE), 32'h1000);
        chk("p900_g0_clip", 32'(bus.CLIP), 32'h0);
        do_reset();
        send(12'h000, 3'd0);
        chk("z_g0_wave", 32'(bus.WAVE), 32'h8000);
        chk("z_g0_clip", 32'(bus.CLIP), 32'h0);

        // 3: saturation both directions
        do_reset();
        send(12'h900, 3'd3);
        chk("p900_g3_wave", 32'(bus.WAVE), 32'h7FFF);
        chk("p900_g3_clip", 32'(bus.CLIP), 32'h1);
        do_reset();
        send(12'h000, 3'd1);
        chk("z_g1_wave", 32'(bus.WAVE), 32'h8000);
        chk("z_g1_clip", 32'(bus.CLIP), 32'h1);

        // 4: DC convergence at the minimum no-overrun spacing
        do_reset();
        bus.GAIN = 3'd0;
        bus.ADC_DATA = 12'hA00;
        prev = 16'sh7FFF;
        for (int n = 0; n < 1000; n++) begin
            bus.ADC_VALID = 1'b1;
            tick();
            bus.ADC_VALID = 1'b0;
            repeat (9) tick();
            cur = $signed(bus.WAVE);
            if (n == 0) chk("dc_first", 32'(bus.WAVE), 32'h2000);
            chk("dc_mono", 32'(cur <= prev), 32'h1);
            prev = cur;
        end
        chk("dc_final_abs", 32'((cur <= 16) && (cur >= -16)), 32'h1);
        chk("dc_ovr", 32'(bus.OVERRUN), 32'h0);

        // 5: oversubscribed input
        do_reset();
        tr_prev = 1'b0; w_prev = bus.WAVE;
        hi_run = 0; lo_run = 0; seen_fall = 1'b0;
        for (int c = 0; c < 120; c++) begin
            bus.ADC_DATA  = 12'(c * 37);
            bus.ADC_VALID = (c % 3 == 0);
            tick();
            if (tr_prev && bus.SAMPLE_TR)
                chk("ovf_wave_stable", 32'(bus.WAVE), 32'(w_prev));
            if (bus.SAMPLE_TR) begin
                if (!tr_prev && seen_fall) chk("ovf_lo_min", 32'(lo_run >= 4), 32'h1);
                hi_run++; lo_run = 0;
            end else begin
                if (tr_prev) begin
                    chk("ovf_hi_len", 32'(hi_run), 32'd4);
                    seen_fall = 1'b1;
                end
                hi_run = 0; lo_run++;
            end
            if (c == 30) chk("ovf_set", 32'(bus.OVERRUN), 32'h1);
            tr_prev = bus.SAMPLE_TR; w_prev = bus.WAVE;
        end
        bus.ADC_VALID = 1'b0;
        repeat (20) tick();
        chk("ovf_sticky", 32'(bus.OVERRUN), 32'h1);

        // 6: reset during the high phase with a sample pending
        do_reset();
        bus.ADC_DATA = 12'h900; bus.ADC_VALID = 1'b1;
        tick();                                   // edge 0
        bus.ADC_VALID = 1'b0;
        tick();                                   // edge 1
        bus.ADC_DATA = 12'h880; bus.ADC_VALID = 1'b1;
        tick();                                   // edge 2
        bus.ADC_VALID = 1'b0;
        chk("rm_wave_pre", 32'(bus.WAVE), 32'h1000);
        tick();                                   // edge 3
        tick();                                   // edge 4
        chk("rm_tr_pre", 32'(bus.SAMPLE_TR), 32'h1);
        rst = 1'b1;
        tick();                                   // edge 5
        rst = 1'b0;
        chk("rm_tr", 32'(bus.SAMPLE_TR), 32'h0);
        chk("rm_wave", 32'(bus.WAVE), 32'h0);
        chk("rm_ovr", 32'(bus.OVERRUN), 32'h0);
        hi_run = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (bus.SAMPLE_TR) hi_run++;
        end
        chk("rm_no_pulse", 32'(hi_run), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
